uart_rx_fifo: RTL and testbench

- Parametrised UART receiver for the MIPS debug/load link. It converts the serial `rx` line into bytes for the DataPath control logic.
- Integrates a baud-tick divider with 16x oversampling, configurable frame format (data bits, parity), error detection and a receive FIFO.
- Successor to the fixed 8N1 receiver inside DataPath. Sits between the `rx` pin and the instruction/data loader.

---
 rtl/uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with 16x oversampling and a receive FIFO.
//
// Parameters:
//   CLKS_PER_TICK - clk cycles per oversample tick (tick = baud*16), >= 2
//   DATA_BITS     - data bits per frame, 5..8
//   PARITY_MODE   - 0 none, 1 even, 2 odd
//   FIFO_DEPTH    - FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   rx             - asynchronous serial input, idle high
//   rd_en          - pop the FIFO head (ignored when empty)
//   err_clr        - clear the sticky error flags
//   rd_data        - FIFO head, first-word-fall-through (0 while empty)
//   empty, full    - FIFO status
//   count          - FIFO occupancy
//   frame_err      - sticky, stop bit sampled low
//   parity_err     - sticky, parity mismatch
//   overrun        - sticky, good frame dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 27,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLKS_PER_TICK);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // Synchroniser plus one history flop for falling-edge detection.
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s2_q;

    // Receive FSM state.
    logic [2:0]           state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [2:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bad_q, bad_d;
    logic                 tick, samp, push, set_frame, set_parity;

    assign tick = (div_q == DW'(CLKS_PER_TICK - 1));
    // Mid-bit sample point for data, parity and stop bits.
    assign samp = tick & (tcnt_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        bad_d      = bad_q;
        push       = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        // Divider free-runs; a start edge restarts it so ticks are phase-aligned to the frame.
        div_d      = tick ? '0 : div_q + DW'(1);
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    div_d   = '0;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = '0;
                        state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) tcnt_d = tcnt_q + 4'd1;  // wraps 15 -> 0 at each sample
                if (samp) begin
                    shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
                    if (bcnt_q == 3'(DATA_BITS - 1)) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) tcnt_d = tcnt_q + 4'd1;
                if (samp) begin
                    // XOR of data and parity bit is 0 for even mode, 1 for odd mode.
                    if ((^shift_q ^ rx_s2_q) != 1'(PARITY_MODE == 2)) begin
                        set_parity = 1'b1;
                        bad_d      = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) tcnt_d = tcnt_q + 4'd1;
                if (samp) begin
                    if (!rx_s2_q) begin
                        set_frame = 1'b1;
                        state_d   = S_BREAK;
                    end else begin
                        push    = ~bad_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            bad_q   <= bad_d;
        end
    end

    // Receive FIFO.
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 pop, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    // Sticky error flags; a new error wins over a same-cycle clear.
    logic frame_err_q, parity_err_q, overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= set_frame  | (frame_err_q  & ~err_clr);
            parity_err_q <= set_parity | (parity_err_q & ~err_clr);
            overrun_q    <= (push & ~wr_en) | (overrun_q & ~err_clr);
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Two instances share clock and reset:
// dut_a is 8N1 with a 4-entry FIFO, dut_p is 8E1 with an 8-entry FIFO.
// One bit time is 16 ticks * 4 clks = 64 clks. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rd_a = 1'b0, clr_a = 1'b0;
    logic       rx_p = 1'b1, rd_p = 1'b0, clr_p = 1'b0;
    logic [7:0] data_a, data_p;
    logic       empty_a, full_a, ferr_a, perr_a, ovr_a;
    logic       empty_p, full_p, ferr_p, perr_p, ovr_p;
    logic [2:0] cnt_a;
    logic [3:0] cnt_p;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_TICK(4), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rd_en(rd_a), .err_clr(clr_a),
        .rd_data(data_a), .empty(empty_a), .full(full_a), .count(cnt_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx_fifo #(.CLKS_PER_TICK(4), .DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .rd_en(rd_p), .err_clr(clr_p),
        .rd_data(data_p), .empty(empty_p), .full(full_p), .count(cnt_p),
        .frame_err(ferr_p), .parity_err(perr_p), .overrun(ovr_p)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx_a = v;
        idle(BIT);
    endtask

    // Start, 8 data bits LSB-first, optional parity, stop. The line is left at the stop level.
    task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                        input logic par_b, input logic stop_b);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (par_en) drive(sel, par_b);
        drive(sel, stop_b);
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
    endtask

    initial begin
        // Reset and idle.
        idle(3);
        rst_n = 1'b1;
        idle(200);
        chk("rst_empty_a", empty_a, 1);
        chk("rst_count_a", cnt_a, 0);
        chk("rst_full_a", full_a, 0);
        chk("rst_data_a", data_a, 0);
        chk("rst_flags_a", {ferr_a, perr_a, ovr_a}, 0);
        chk("rst_empty_p", empty_p, 1);
        chk("rst_flags_p", {ferr_p, perr_p, ovr_p}, 0);

        // Single 8N1 frame; the stop bit is sampled near its middle (~608 clks after the start edge).
        fork
            send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                idle(600);
                chk("a5_before_stop", empty_a, 1);
                idle(20);
                chk("a5_after_stop", empty_a, 0);
            end
        join
        idle(16);
        chk("a5_data", data_a, 8'hA5);
        chk("a5_count", cnt_a, 1);
        pop_a();
        chk("a5_pop_empty", empty_a, 1);
        chk("a5_pop_count", cnt_a, 0);
        pop_a();  // pop while empty is ignored
        chk("pop_empty_count", cnt_a, 0);

        // Even parity: 0x3C has four ones, so parity bit 0 is good and 1 is bad.
        send(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        idle(16);
        chk("par_good_count", cnt_p, 1);
        chk("par_good_data", data_p, 8'h3C);
        chk("par_good_flag", perr_p, 0);
        send(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        idle(16);
        chk("par_bad_count", cnt_p, 1);
        chk("par_bad_flag", perr_p, 1);
        idle(100);
        chk("par_bad_hold", perr_p, 1);
        clr_p = 1'b1;
        @(negedge clk);
        clr_p = 1'b0;
        chk("par_clr", perr_p, 0);
        // 0x07 has three ones: even parity bit must be 1.
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(16);
        chk("par_odd_ones_count", cnt_p, 2);
        chk("par_odd_ones_flag", perr_p, 0);

        // Frame error followed by a held-low break.
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(500);
        chk("ferr_set", ferr_a, 1);
        chk("ferr_nopush", cnt_a, 0);
        rx_a = 1'b1;
        idle(200);
        chk("break_nopush", cnt_a, 0);
        chk("break_no_perr", perr_a, 0);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ferr_clr", ferr_a, 0);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(16);
        chk("after_break_data", data_a, 8'h5A);
        pop_a();

        // Overrun and pointer wrap on the 4-entry FIFO (write pointer now at 2).
        for (int i = 1; i <= 4; i++) begin
            send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            idle(16);
        end
        chk("ovr_full", full_a, 1);
        chk("ovr_count4", cnt_a, 4);
        chk("ovr_not_yet", ovr_a, 0);
        send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        idle(16);
        chk("ovr_set", ovr_a, 1);
        chk("ovr_count_held", cnt_a, 4);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_read%0d", i), data_a, i);
            pop_a();
        end
        chk("ovr_drained", empty_a, 1);
        for (int i = 6; i <= 8; i++) begin
            send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            idle(16);
        end
        chk("wrap_count", cnt_a, 3);
        for (int i = 6; i <= 8; i++) begin
            chk($sformatf("wrap_read%0d", i), data_a, i);
            pop_a();
        end
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovr_clr", ovr_a, 0);

        // 20-clk glitch is a false start.
        rx_a = 1'b0;
        idle(20);
        rx_a = 1'b1;
        idle(700);
        chk("glitch_empty", empty_a, 1);
        chk("glitch_flags", {ferr_a, perr_a, ovr_a}, 0);

        // Reset in the middle of the data bits, then a clean 0x7E frame.
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        idle(20);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(100);
        chk("midrst_empty", empty_a, 1);
        chk("midrst_count", cnt_a, 0);
        send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        idle(16);
        chk("midrst_data", data_a, 8'h7E);
        chk("midrst_count1", cnt_a, 1);
        chk("midrst_flags", {ferr_a, perr_a, ovr_a}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
